// File: rtl/fpgasynth_led_ctrl.sv
// fpgasynth_led_ctrl: drives the 10-bit board LED bank.
// The LEDs can show one of three sources:
//   - a CPU-written pattern,
//   - pulse-stretched voice-gate activity,
//   - a decaying bar-graph level meter.
// A small Avalon-MM slave exposes configuration and status.
module fpgasynth_led_ctrl #(
    parameter int          TICK_DIV   = 50000,
    parameter logic [15:0] HOLD_RESET = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  voice_gate,
    input  logic [15:0] level,
    input  logic        level_valid,
    output logic [9:0]  out_port
);

    localparam int                DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_CPU   = 2'd0,
        MODE_ACT   = 2'd1,
        MODE_METER = 2'd2,
        MODE_AUTO  = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_HOLD    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // State
    logic [DIV_W-1:0] div_q, div_d;
    mode_e            mode_q, mode_d;
    logic             blink_en_q, blink_en_d;
    logic [9:0]       pattern_q, pattern_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      cnt_q [10];
    logic [15:0]      cnt_d [10];
    logic [3:0]       peak_q, peak_d;
    logic [3:0]       blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [9:0]       out_port_q, out_port_d;

    // Combinational helpers
    logic       tick;
    logic       wr_en;
    logic [9:0] act;
    logic       any_act;
    logic [3:0] bar;
    logic [9:0] meter_pat;
    logic [9:0] sel_pat;

    // Writedata above the widest register and the low level bits carry nothing here.
    logic unused_bits;
    assign unused_bits = ^{writedata[31:16], level[11:0]};

    // Display-tick prescaler: one-cycle tick at the top of the count, then wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Avalon register writes; STATUS is read-only so address 3 writes fall through.
    always_comb begin
        wr_en      = chipselect & ~write_n;
        mode_d     = mode_q;
        blink_en_d = blink_en_q;
        pattern_d  = pattern_q;
        hold_d     = hold_q;
        if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    mode_d     = mode_e'(writedata[1:0]);
                    blink_en_d = writedata[2];
                end
                ADDR_PATTERN: pattern_d = writedata[9:0];
                ADDR_HOLD:    hold_d    = writedata[15:0];
                default:      ;
            endcase
        end
    end

    // Per-LED pulse stretcher: a live gate reloads HOLD, otherwise the count decays one per tick.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            cnt_d[i] = cnt_q[i];
            act[i]   = voice_gate[i] | (cnt_q[i] != 16'd0);
            if (voice_gate[i]) begin
                cnt_d[i] = hold_q;
            end else if (tick && cnt_q[i] != 16'd0) begin
                cnt_d[i] = cnt_q[i] - 16'd1;
            end
        end
        any_act = |act;
    end

    // Peak-hold meter: a new sample at or above the peak wins over the tick decay.
    always_comb begin
        bar    = (level[15:12] > 4'd10) ? 4'd10 : level[15:12];
        peak_d = peak_q;
        if (level_valid && bar >= peak_q) begin
            peak_d = bar;
        end else if (tick && peak_q != 4'd0) begin
            peak_d = peak_q - 4'd1;
        end
        // peak never exceeds 10, so the shifted one stays inside 11 bits.
        meter_pat = 10'((11'd1 << peak_q) - 11'd1);
    end

    // Blink phase flips once every 16 ticks.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            blink_cnt_d = blink_cnt_q + 4'd1;
            if (blink_cnt_q == 4'hF) begin
                blink_phase_d = ~blink_phase_q;
            end
        end
    end

    // Source select and blink gating ahead of the output register.
    always_comb begin
        case (mode_q)
            MODE_CPU:   sel_pat = pattern_q;
            MODE_ACT:   sel_pat = act;
            MODE_METER: sel_pat = meter_pat;
            MODE_AUTO:  sel_pat = any_act ? act : meter_pat;
            default:    sel_pat = pattern_q;
        endcase
        out_port_d = (blink_en_q && blink_phase_q) ? 10'd0 : sel_pat;
    end

    // Zero-wait-state read mux.
    always_comb begin
        case (address)
            ADDR_CTRL:    readdata = {29'd0, blink_en_q, mode_q};
            ADDR_PATTERN: readdata = {22'd0, pattern_q};
            ADDR_HOLD:    readdata = {16'd0, hold_q};
            ADDR_STATUS:  readdata = {15'd0, any_act, 2'd0, peak_q, out_port_q};
            default:      readdata = 32'd0;
        endcase
    end

    assign out_port = out_port_q;

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            div_q         <= '0;
            mode_q        <= MODE_CPU;
            blink_en_q    <= 1'b0;
            pattern_q     <= 10'd0;
            hold_q        <= HOLD_RESET;
            peak_q        <= 4'd0;
            blink_cnt_q   <= 4'd0;
            blink_phase_q <= 1'b0;
            out_port_q    <= 10'd0;
            // NOTE: the stretch counters are cleared too, otherwise a reset mid-stretch leaves LEDs lit.
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            div_q         <= div_d;
            mode_q        <= mode_d;
            blink_en_q    <= blink_en_d;
            pattern_q     <= pattern_d;
            hold_q        <= hold_d;
            peak_q        <= peak_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            out_port_q    <= out_port_d;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fpgasynth_led_ctrl.sv
// Bench for fpgasynth_led_ctrl.
// A behavioural model predicts out_port and readdata every cycle.
// Directed scenarios add literal expectations that pin the model.
module tb_fpgasynth_led_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  voice_gate;
    logic [15:0] level;
    logic        level_valid;
    logic [9:0]  out_port;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    fpgasynth_led_ctrl #(.TICK_DIV(TD), .HOLD_RESET(16'd100)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .voice_gate  (voice_gate),
        .level       (level),
        .level_valid (level_valid),
        .out_port    (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_cycles;      // cycles since reset released
    int unsigned m_ticks;       // ticks since reset released
    logic [2:0]  m_ctrl;
    logic [9:0]  m_pattern;
    logic [15:0] m_hold;
    int          m_rem [10];    // ticks of stretch still to run per LED
    int          m_peak;
    logic [9:0]  m_out;

    logic [9:0]  mv_act, mv_sel;
    bit          mv_tick, mv_blank;
    int          mv_bar;

    function automatic logic [9:0] model_act();
        logic [9:0] a;
        for (int i = 0; i < 10; i++) a[i] = voice_gate[i] || (m_rem[i] > 0);
        return a;
    endfunction

    function automatic logic [9:0] model_meter();
        logic [9:0] p = 10'd0;
        for (int i = 0; i < 10; i++) p[i] = (i < m_peak);
        return p;
    endfunction

    function automatic logic [31:0] model_rd();
        logic [31:0] r;
        logic [3:0]  pk = 4'(m_peak);
        case (address)
            2'd0:    r = {29'd0, m_ctrl};
            2'd1:    r = {22'd0, m_pattern};
            2'd2:    r = {16'd0, m_hold};
            default: r = {15'd0, |model_act(), 2'd0, pk, m_out};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cycles  = 0;
            m_ticks   = 0;
            m_ctrl    = 3'd0;
            m_pattern = 10'd0;
            m_hold    = 16'd100;
            m_peak    = 0;
            m_out     = 10'd0;
            for (int i = 0; i < 10; i++) m_rem[i] = 0;
        end else begin
            mv_tick = (m_cycles % TD) == TD - 1;
            mv_act  = model_act();
            case (m_ctrl[1:0])
                2'd0:    mv_sel = m_pattern;
                2'd1:    mv_sel = mv_act;
                2'd2:    mv_sel = model_meter();
                default: mv_sel = (|mv_act) ? mv_act : model_meter();
            endcase
            mv_blank = m_ctrl[2] && (((m_ticks / 16) % 2) == 1);
            m_out    = mv_blank ? 10'd0 : mv_sel;
            for (int i = 0; i < 10; i++) begin
                if (voice_gate[i]) m_rem[i] = int'(m_hold);
                else if (mv_tick && m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
            end
            mv_bar = int'(level[15:12]);
            if (mv_bar > 10) mv_bar = 10;
            if (level_valid && mv_bar >= m_peak) m_peak = mv_bar;
            else if (mv_tick && m_peak > 0) m_peak = m_peak - 1;
            if (chipselect && !write_n) begin
                case (address)
                    2'd0:    m_ctrl    = writedata[2:0];
                    2'd1:    m_pattern = writedata[9:0];
                    2'd2:    m_hold    = writedata[15:0];
                    default: ;
                endcase
            end
            m_cycles++;
            if (mv_tick) m_ticks++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_port_model", {22'd0, out_port}, {22'd0, m_out});
            check("readdata_model", readdata, model_rd());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Both expect tasks sample at the next negedge and return just after the following posedge.
    task automatic expect_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        check(name, readdata, exp);
        cyc(1);
    endtask

    task automatic expect_out(input string name, input logic [9:0] exp);
        @(negedge clk);
        check(name, {22'd0, out_port}, {22'd0, exp});
        cyc(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int on_cnt;

    initial begin
        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        voice_gate  = 10'd0;
        level       = 16'd0;
        level_valid = 1'b0;
        cyc(1);
        cmp_en = 1'b1;
        cyc(2);
        reset = 1'b0;

        // Reset state
        expect_rd("rst_ctrl", 2'd0, 32'd0);
        expect_rd("rst_pattern", 2'd1, 32'd0);
        expect_rd("rst_hold", 2'd2, 32'd100);
        expect_rd("rst_status", 2'd3, 32'd0);
        expect_out("rst_out", 10'd0);

        // Mode 0: CPU pattern, one-cycle latency, STATUS write ignored
        wr(2'd1, 32'h0000_02A5);
        expect_out("pat_latency", 10'd0);
        expect_out("pat_out", 10'h2A5);
        expect_rd("pat_read", 2'd1, 32'h2A5);
        wr(2'd3, 32'hFFFF_FFFF);
        expect_rd("status_ro", 2'd3, 32'h2A5);

        // Mode 1: stretch with HOLD=3, then a re-gate reload
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        cyc(2);
        voice_gate = 10'h010;
        cyc(1);
        voice_gate = 10'h000;
        expect_out("act_gate", 10'h010);
        cyc(5);
        voice_gate = 10'h010;
        cyc(1);
        voice_gate = 10'h000;
        cyc(7);
        expect_out("act_regate_hold", 10'h010);
        cyc(6);
        expect_out("act_expired", 10'h000);

        // Mode 2: full-scale meter, decay, then sample-over-tick priority
        wr(2'd0, 32'd2);
        level       = 16'hF000;
        level_valid = 1'b1;
        cyc(1);
        level_valid = 1'b0;
        cyc(1);
        expect_out("meter_full", 10'h3FF);
        cyc(50);
        expect_out("meter_decayed", 10'h000);
        level       = 16'h5000;
        level_valid = 1'b1;
        cyc(1);
        for (int k = 0; k < 2 * TD && (m_cycles % TD) != TD - 1; k++) cyc(1);
        cyc(1);
        level_valid = 1'b0;
        expect_rd("meter_priority", 2'd3, 32'h0000_141F);

        // Mode 3: meter at peak 6, gated voice 9 takes over, then meter resumes
        wr(2'd0, 32'd3);
        level       = 16'h6000;
        level_valid = 1'b1;
        cyc(2);
        expect_out("auto_meter", 10'h03F);
        voice_gate = 10'h200;
        cyc(1);
        voice_gate = 10'h000;
        expect_out("auto_act", 10'h200);
        cyc(20);
        expect_out("auto_resume", 10'h03F);
        level_valid = 1'b0;
        level       = 16'h0000;

        // Blink over one full 128-cycle period
        wr(2'd1, 32'h3FF);
        wr(2'd0, 32'h4);
        cyc(2);
        on_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (out_port == 10'h3FF) on_cnt++;
            cyc(1);
        end
        check("blink_duty", 32'(on_cnt), 32'd64);

        // Reset mid-blink
        reset = 1'b1;
        cyc(1);
        expect_out("midrst_out", 10'd0);
        reset = 1'b0;
        expect_rd("midrst_ctrl", 2'd0, 32'd0);
        expect_rd("midrst_pattern", 2'd1, 32'd0);
        expect_rd("midrst_hold", 2'd2, 32'd100);
        expect_rd("midrst_status", 2'd3, 32'd0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpgasynth_led_ctrl.md
# fpgaSynth_led_ctrl

LED display controller that sits in front of the 10-bit board LED bank and decides what it shows. It shares the LEDs between three sources: a CPU-written pattern, pulse-stretched voice-gate activity from the synth voices, and a decaying bar-graph level meter fed from the audio path. Configuration and status are exposed through a small Avalon-MM slave on the system interconnect. The registered result drives the LED pins directly.

## Interface

Parameters:
- TICK_DIV, 50000: clk cycles per display tick (1 kHz at 50 MHz); legal range ≥2.
- HOLD_RESET, 16'd100: reset value of the HOLD register.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- voice_gate  in  10  per-voice gate, bit i maps to LED i.
- level  in  16  unsigned audio amplitude.
- level_valid  in  1  one-cycle qualifier for level.
- out_port  out  10  LED drive; registered.

## Operation

- Registers (write = chipselect & ~write_n; unused bits read 0):
  - 0 CTRL: [1:0] mode (0 CPU, 1 activity, 2 meter, 3 auto); [2] blink_en. Resets to 0.
  - 1 PATTERN: [9:0] CPU pattern. Resets to 0.
  - 2 HOLD: [15:0] stretch length in ticks. Resets to HOLD_RESET.
  - 3 STATUS (read-only, writes ignored): [9:0] out_port, [13:10] peak, [16] any_act.
- Tick prescaler: counter 0..TICK_DIV-1. tick=1 for the single cycle in which counter==TICK_DIV-1; the counter then wraps to 0. Resets to 0.
- Activity, per LED i:
  - 16-bit stretch counter cnt[i].
  - If voice_gate[i]=1, cnt[i] is loaded with HOLD every cycle.
  - Otherwise, on tick with cnt[i]≠0, cnt[i] decrements by 1.
  - act[i] = voice_gate[i] | (cnt[i]≠0).
  - any_act = |act.
  - If HOLD=0, act follows voice_gate exactly.
- Meter:
  - bar = level[15:12], clamped to 10 (values 10..15 give 10).
  - 4-bit peak register, reset 0.
  - If level_valid and bar≥peak, peak←bar. This has priority over a same-cycle tick.
  - Otherwise, on tick with peak>0, peak←peak-1.
  - Meter pattern is a thermometer: LEDs [peak-1:0] lit; all off when peak=0.
- Source select:
  - Mode 0 selects PATTERN.
  - Mode 1 selects act.
  - Mode 2 selects the meter pattern.
  - Mode 3 selects act if any_act, else the meter pattern.
- Blink:
  - blink_phase toggles on every 16th tick, using a 4-bit tick counter. The phase counter and blink_phase reset to 0.
  - When blink_en=1 and blink_phase=1, the selected pattern is forced to 0.
- out_port is registered from the selected pattern.
- All state (counters, registers, peak, blink) returns to its reset value on reset, including mid-stretch and mid-decay.

## Timing

- Reset values: out_port=0, readdata reflects register reset values.
- out_port latency is 1 cycle from any change in a register, voice_gate, act, or peak.
- A register write at edge N is readable in cycle N+1. Its effect reaches out_port at edge N+1.
- level_valid at edge N updates peak at N. The LED change is visible after edge N+1.
- A gate falling at edge N with HOLD=H keeps act high until the H-th subsequent tick, then act clears on that tick edge.
- Changing HOLD does not alter counters already decrementing. The new value is used only on the next reload.
- Changing mode takes effect on the next cycle; no stretch or peak state is lost.

## Test plan

- Reset, then read all four addresses: CTRL=0, PATTERN=0, HOLD=100, STATUS=0; out_port=0.
- Mode 0: write PATTERN=0x2A5 -> out_port=0x2A5 one cycle after the write; write to address 3 -> STATUS unchanged.
- TICK_DIV=4, mode 1, HOLD=3: pulse voice_gate[4] for 1 cycle -> out_port bit 4 high for 3 ticks (about 12 cycles), then 0. A re-gate mid-stretch reloads to 3.
- Mode 2: level_valid with level=0xF000 -> peak=10, out_port=0x3FF. Then, with no input, peak decays one LED per tick to 0. A same-cycle valid with level=0x5000 and tick -> peak=5, not a decrement.
- Mode 3: meter at peak 6 (0x03F), then gate voice 9 -> out_port=0x200. After the stretch expires -> meter display resumes.
- Blink_en=1, mode 0, PATTERN=0x3FF, TICK_DIV=4 -> out_port alternates 0x3FF and 0 every 64 cycles. Assert reset mid-blink -> out_port=0 on the next cycle and all registers return to their reset values.
